// File: rtl/vga640x360.sv
// ---------------------------------------------------------------------------
// vga640x360
//   VGA timing generator for a 640x360 letterboxed picture centred inside a
//   standard 640x480 @ 60 Hz frame (800 x 525 total pixel clocks).
//   The block runs on the fast system clock. Its horizontal and vertical
//   counters advance only on cycles where the external pixel strobe is high.
//   Every output is a combinational decode of the two counters, so all
//   outputs change together, on the same clock edge as the counters.
//
// Ports
//   i_clk        system clock
//   i_rst        asynchronous, active-high reset; clears both counters
//   i_pix_stb    pixel enable; the counters advance only when this is high
//   o_hs         horizontal sync, active low
//   o_vs         vertical sync, active low
//   o_blanking   high outside the 640x360 active window
//   o_active     high inside the 640x360 active window
//   o_screenend  high for the last pixel of the frame
//   o_animate    high for the last pixel of the last active line
//   o_x          pixel column 0..639 (0 during left blanking)
//   o_y          pixel row 0..359 (clamped during top and bottom blanking)
// ---------------------------------------------------------------------------
module vga640x360 #(
  parameter int HS_STA = 16,
  parameter int HS_END = 112,
  parameter int HA_STA = 160,
  parameter int VS_STA = 490,
  parameter int VS_END = 492,
  parameter int VA_STA = 60,
  parameter int VA_END = 420,
  parameter int LINE   = 800,
  parameter int SCREEN = 525
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_stb,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_blanking,
  output logic       o_active,
  output logic       o_screenend,
  output logic       o_animate,
  output logic [9:0] o_x,
  output logic [8:0] o_y
);

  localparam logic [9:0] HS_STA_C    = 10'(HS_STA);
  localparam logic [9:0] HS_END_C    = 10'(HS_END);
  localparam logic [9:0] HA_STA_C    = 10'(HA_STA);
  localparam logic [9:0] VS_STA_C    = 10'(VS_STA);
  localparam logic [9:0] VS_END_C    = 10'(VS_END);
  localparam logic [9:0] VA_STA_C    = 10'(VA_STA);
  localparam logic [9:0] VA_END_C    = 10'(VA_END);
  localparam logic [9:0] VA_LAST_C   = 10'(VA_END - 1);
  localparam logic [9:0] LINE_LAST   = 10'(LINE - 1);
  localparam logic [9:0] SCREEN_LAST = 10'(SCREEN - 1);
  localparam logic [8:0] VA_STA_Y    = 9'(VA_STA);
  localparam logic [8:0] Y_MAX       = 9'(VA_END - VA_STA - 1);

  logic [9:0] h_count_q, h_count_d;
  logic [9:0] v_count_q, v_count_d;

  // Raster scan: h wraps at the end of each line and carries into v.
  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (i_pix_stb) begin
      if (h_count_q == LINE_LAST) begin
        h_count_d = '0;
        v_count_d = (v_count_q == SCREEN_LAST) ? '0 : v_count_q + 10'd1;
      end else begin
        h_count_d = h_count_q + 10'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_count_q <= '0;
      v_count_q <= '0;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
    end
  end

  assign o_hs = !((h_count_q >= HS_STA_C) && (h_count_q < HS_END_C));
  assign o_vs = !((v_count_q >= VS_STA_C) && (v_count_q < VS_END_C));

  assign o_blanking = (h_count_q < HA_STA_C) || (v_count_q < VA_STA_C) ||
                      (v_count_q >= VA_END_C);
  assign o_active   = !o_blanking;

  assign o_screenend = (v_count_q == SCREEN_LAST) && (h_count_q == LINE_LAST);
  assign o_animate   = (v_count_q == VA_LAST_C) && (h_count_q == LINE_LAST);

  assign o_x = (h_count_q < HA_STA_C) ? '0 : (h_count_q - HA_STA_C);

  // The 9-bit subtraction wraps modulo 512. That gives the same low bits as
  // a 10-bit subtraction, and the row is always below 512 in the window.
  assign o_y = (v_count_q < VA_STA_C)  ? '0    :
               (v_count_q >= VA_END_C) ? Y_MAX :
               (v_count_q[8:0] - VA_STA_Y);

endmodule

// File: tb/tb_vga640x360.sv
module tb_vga640x360;

  localparam int W = 25;

  // Reduced-geometry copy so whole frames fit in a short run.
  localparam int S_HS_STA = 2;
  localparam int S_HS_END = 7;
  localparam int S_HA_STA = 10;
  localparam int S_VS_STA = 26;
  localparam int S_VS_END = 28;
  localparam int S_VA_STA = 4;
  localparam int S_VA_END = 24;
  localparam int S_LINE   = 40;
  localparam int S_SCREEN = 30;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic stb;

  logic       d_hs, d_vs, d_blank, d_active, d_se, d_an;
  logic [9:0] d_x;
  logic [8:0] d_y;
  logic       s_hs, s_vs, s_blank, s_active, s_se, s_an;
  logic [9:0] s_x;
  logic [8:0] s_y;

  vga640x360 dut (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb),
    .o_hs(d_hs), .o_vs(d_vs), .o_blanking(d_blank), .o_active(d_active),
    .o_screenend(d_se), .o_animate(d_an), .o_x(d_x), .o_y(d_y)
  );

  vga640x360 #(
    .HS_STA(S_HS_STA), .HS_END(S_HS_END), .HA_STA(S_HA_STA),
    .VS_STA(S_VS_STA), .VS_END(S_VS_END), .VA_STA(S_VA_STA),
    .VA_END(S_VA_END), .LINE(S_LINE), .SCREEN(S_SCREEN)
  ) dut_s (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb),
    .o_hs(s_hs), .o_vs(s_vs), .o_blanking(s_blank), .o_active(s_active),
    .o_screenend(s_se), .o_animate(s_an), .o_x(s_x), .o_y(s_y)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int md_h = 0, md_v = 0;
  int ms_h = 0, ms_v = 0;
  int stb_cnt = 0;
  logic [W-1:0] exp_d_q[$];
  logic [W-1:0] exp_s_q[$];

  function automatic logic [W-1:0] model(input int h, input int v,
      input int hs_sta, input int hs_end, input int ha_sta,
      input int vs_sta, input int vs_end, input int va_sta,
      input int va_end, input int line, input int screen);
    logic hs, vs, bl, ac, se, an;
    logic [9:0] x;
    logic [8:0] y;
    hs = !(h >= hs_sta && h < hs_end);
    vs = !(v >= vs_sta && v < vs_end);
    bl = (h < ha_sta) || (v < va_sta) || (v >= va_end);
    ac = !bl;
    se = (v == screen - 1) && (h == line - 1);
    an = (v == va_end - 1) && (h == line - 1);
    x  = (h < ha_sta) ? 10'd0 : 10'(h - ha_sta);
    if (v < va_sta)        y = 9'd0;
    else if (v >= va_end)  y = 9'(va_end - va_sta - 1);
    else                   y = 9'(v - va_sta);
    return {hs, vs, bl, ac, se, an, x, y};
  endfunction

  function automatic logic [W-1:0] exp_d();
    return model(md_h, md_v, 16, 112, 160, 490, 492, 60, 420, 800, 525);
  endfunction

  function automatic logic [W-1:0] exp_s();
    return model(ms_h, ms_v, S_HS_STA, S_HS_END, S_HA_STA, S_VS_STA,
                 S_VS_END, S_VA_STA, S_VA_END, S_LINE, S_SCREEN);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input logic s);
    stb = s;
    @(posedge clk);
    #1;
    if (rst) begin
      md_h = 0; md_v = 0; ms_h = 0; ms_v = 0;
    end else if (s) begin
      stb_cnt++;
      if (md_h == 799) begin md_h = 0; md_v = (md_v == 524) ? 0 : md_v + 1; end
      else md_h++;
      if (ms_h == S_LINE - 1) begin ms_h = 0; ms_v = (ms_v == S_SCREEN - 1) ? 0 : ms_v + 1; end
      else ms_h++;
    end
    exp_d_q.push_back(exp_d());
    exp_s_q.push_back(exp_s());
  endtask

  // One pixel period at the 1-in-4 strobe rate.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0); tick(1'b0); tick(1'b0); tick(1'b1);
    end
  endtask

  task automatic run_until_s(input int h, input int v);
    int k;
    k = 0;
    while (!(ms_h == h && ms_v == v) && k < 2500) begin
      step(1);
      k++;
    end
    check($sformatf("reach_s_%0d_%0d", h, v), 32'(ms_h == h && ms_v == v), 32'd1);
  endtask

  logic se_prev = 1'b0;
  logic se_valid = 1'b0;
  int   se_last = 0;

  task automatic reset_checks();
    check("rst_d_hs", 32'(d_hs), 32'd1);
    check("rst_d_vs", 32'(d_vs), 32'd1);
    check("rst_d_x", 32'(d_x), 32'd0);
    check("rst_d_y", 32'(d_y), 32'd0);
    check("rst_d_active", 32'(d_active), 32'd0);
    check("rst_d_blank", 32'(d_blank), 32'd1);
    check("rst_d_se", 32'(d_se), 32'd0);
    check("rst_d_an", 32'(d_an), 32'd0);
    check("rst_s_x", 32'(s_x), 32'd0);
    check("rst_s_y", 32'(s_y), 32'd0);
    check("rst_s_active", 32'(s_active), 32'd0);
  endtask

  // Raise reset between clock edges and look immediately.
  task automatic reset_async();
    #2;
    exp_d_q.delete();
    exp_s_q.delete();
    rst = 1'b1;
    md_h = 0; md_v = 0; ms_h = 0; ms_v = 0;
    se_valid = 1'b0;
    #1;
    reset_checks();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (exp_d_q.size() > 0)
      check("sb_def", 32'({d_hs, d_vs, d_blank, d_active, d_se, d_an, d_x, d_y}),
            32'(exp_d_q.pop_front()));
    if (exp_s_q.size() > 0)
      check("sb_scl", 32'({s_hs, s_vs, s_blank, s_active, s_se, s_an, s_x, s_y}),
            32'(exp_s_q.pop_front()));
    if (s_se && !se_prev && !rst) begin
      if (se_valid) check("se_period", 32'(stb_cnt - se_last), 32'(S_LINE * S_SCREEN));
      se_last  = stb_cnt;
      se_valid = 1'b1;
    end
    se_prev = s_se;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b0;
    stb = 1'b0;
    #1 rst = 1'b1;
    #1 reset_checks();
    tick(1'b1); tick(1'b1); tick(1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Horizontal sync placement and line length on the full-size instance.
    step(15);  check("hs_h15", 32'(d_hs), 32'd1);
    step(1);   check("hs_h16", 32'(d_hs), 32'd0);
    step(95);  check("hs_h111", 32'(d_hs), 32'd0);
    step(1);   check("hs_h112", 32'(d_hs), 32'd1);
    step(687); check("x_h799", 32'(d_x), 32'd639);
               check("y_v0", 32'(d_y), 32'd0);
               check("blank_v0", 32'(d_blank), 32'd1);
    step(1);   check("x_wrap", 32'(d_x), 32'd0);
               check("hs_wrap", 32'(d_hs), 32'd1);
    step(16);  check("hs_line2", 32'(d_hs), 32'd0);

    // Strobe held low mid-line: everything freezes.
    step(184); check("x_h200", 32'(d_x), 32'd40);
    for (int i = 0; i < 100; i++) tick(1'b0);
    check("hold_x", 32'(d_x), 32'd40);
    check("hold_y", 32'(d_y), 32'd0);
    check("hold_hs", 32'(d_hs), 32'd1);
    check("hold_vs", 32'(d_vs), 32'd1);
    step(1);   check("resume_x", 32'(d_x), 32'd41);

    // Active window corners, animate, vsync lines and frame end (reduced).
    run_until_s(S_HA_STA, S_VA_STA);
    check("first_act", 32'(s_active), 32'd1);
    check("first_x", 32'(s_x), 32'd0);
    check("first_y", 32'(s_y), 32'd0);
    run_until_s(S_LINE - 1, S_VA_END - 1);
    check("last_x", 32'(s_x), 32'(S_LINE - S_HA_STA - 1));
    check("last_y", 32'(s_y), 32'(S_VA_END - S_VA_STA - 1));
    check("animate", 32'(s_an), 32'd1);
    step(1);
    check("post_act", 32'(s_active), 32'd0);
    check("post_y", 32'(s_y), 32'(S_VA_END - S_VA_STA - 1));
    check("post_an", 32'(s_an), 32'd0);
    run_until_s(S_LINE - 1, S_VS_STA - 1); check("vs_before", 32'(s_vs), 32'd1);
    step(1);                               check("vs_first", 32'(s_vs), 32'd0);
    run_until_s(S_LINE - 1, S_VS_END - 1); check("vs_last", 32'(s_vs), 32'd0);
    step(1);                               check("vs_after", 32'(s_vs), 32'd1);
    run_until_s(S_LINE - 1, S_SCREEN - 1); check("screenend", 32'(s_se), 32'd1);
    step(1);
    check("se_drop", 32'(s_se), 32'd0);
    check("wrap_x", 32'(s_x), 32'd0);
    check("wrap_y", 32'(s_y), 32'd0);
    check("wrap_blank", 32'(s_blank), 32'd1);
    run_until_s(S_LINE - 1, S_SCREEN - 1); check("screenend2", 32'(s_se), 32'd1);
    step(1);

    // Reset in mid-frame, then time the first active pixel.
    run_until_s(20, 18);
    reset_async();
    tick(1'b1); tick(1'b1); tick(1'b1); tick(1'b1);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!s_active && n < 1000) begin
      step(1);
      n++;
    end
    check("first_active_after_rst", 32'(n), 32'(S_VA_STA * S_LINE + S_HA_STA));
    check("d_x_after_rst", 32'(d_x), 32'd10);
    check("d_blank_after_rst", 32'(d_blank), 32'd1);
    step(3);

    @(negedge clk);
    #1;
    check("q_drain", 32'(exp_d_q.size() + exp_s_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
